// File: rtl/nona_pkg.sv
// Shared types, opcode/funct constants and helpers for the nona RV64I-subset core.
package nona_pkg;

    typedef logic [63:0] xlen_t;
    typedef logic [31:0] inst_t;

    // Major opcodes
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch / jump funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    // funct7 variants
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    function automatic xlen_t sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/nona_if.sv
// Instruction fetch bus between the core and its instruction ROM.
interface nona_if #(
    parameter int unsigned AW = 12
);
    import nona_pkg::*;

    logic [AW-1:0] addr;
    inst_t         data;
    // Backdoor image load channel; the core ties it off, images normally arrive by preloading the ROM array.
    logic          load_en;
    logic [AW-1:0] load_addr;
    inst_t         load_data;

    modport master (output addr, output load_en, output load_addr, output load_data, input data);
    modport slave  (input addr, input load_en, input load_addr, input load_data, output data);

endinterface

// File: rtl/nona_core.sv
// Single-cycle RV64I-subset core: fetch, decode, ALU and register file in one cycle.
module nona_core
    import nona_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 4096,
    parameter xlen_t       RESET_PC  = '0
) (
    input logic clk_i,
    input logic rst_ni
);

    localparam int unsigned AW = $clog2(ROM_DEPTH);

    xlen_t   pc_q;
    inst_t   ir;
    xlen_t   regs [32];

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    xlen_t   imm_i;
    xlen_t   imm_u;
    xlen_t   imm_b;
    xlen_t   imm_j;
    xlen_t   rs1_val;
    xlen_t   rs2_val;

    alu_op_t alu_op;
    xlen_t   alu_a;
    xlen_t   alu_b;
    logic    alu_word;
    xlen_t   alu_res;
    xlen_t   alu_raw;
    logic [31:0] alu_wres;

    logic    rd_we;
    logic    link;
    logic    is_jal;
    logic    is_jalr;
    logic    is_branch;
    logic    br_taken;
    xlen_t   pc_plus4;
    xlen_t   pc_target;
    xlen_t   pc_next;
    xlen_t   wb_data;

    nona_if #(.AW(AW)) rom_bus ();

    nona_rom #(.ROM_DEPTH(ROM_DEPTH)) async_rom (
        .clk_i (clk_i),
        .bus   (rom_bus.slave)
    );

    // Fetch: word address from PC, upper PC bits ignored so fetches wrap
    always_comb begin
        rom_bus.addr      = pc_q[2 +: AW];
        rom_bus.load_en   = 1'b0;
        rom_bus.load_addr = '0;
        rom_bus.load_data = '0;
        ir                = rom_bus.data;
    end

    // Field extraction, immediates and register reads (x0 always reads zero)
    always_comb begin
        opcode  = ir[6:0];
        rd      = ir[11:7];
        funct3  = ir[14:12];
        rs1     = ir[19:15];
        rs2     = ir[24:20];
        funct7  = ir[31:25];
        imm_i   = {{52{ir[31]}}, ir[31:20]};
        imm_u   = {{32{ir[31]}}, ir[31:12], 12'b0};
        imm_b   = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        imm_j   = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
        rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
    end

    // Decode: select ALU operation/operands; unrecognised encodings leave rd_we low (NOP)
    always_comb begin
        alu_op    = ALU_ADD;
        alu_a     = rs1_val;
        alu_b     = imm_i;
        alu_word  = 1'b0;
        rd_we     = 1'b0;
        link      = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_a = '0;
                alu_b = imm_u;
                rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a = pc_q;
                alu_b = imm_u;
                rd_we = 1'b1;
            end
            OPC_JAL: begin
                is_jal = 1'b1;
                link   = 1'b1;
                rd_we  = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == F3_JALR) begin
                    is_jalr = 1'b1;
                    link    = 1'b1;
                    rd_we   = 1'b1;
                end
            end
            OPC_BRANCH: begin
                is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_OP_IMM: begin
                rd_we = 1'b1;
                case (funct3)
                    F3_ADD_SUB: alu_op = ALU_ADD;
                    F3_SLT:     alu_op = ALU_SLT;
                    F3_SLTU:    alu_op = ALU_SLTU;
                    F3_XOR:     alu_op = ALU_XOR;
                    F3_OR:      alu_op = ALU_OR;
                    F3_AND:     alu_op = ALU_AND;
                    F3_SLL: begin
                        alu_op = ALU_SLL;
                        rd_we  = (ir[31:26] == 6'b0);
                    end
                    F3_SRL_SRA: begin
                        alu_op = ir[30] ? ALU_SRA : ALU_SRL;
                        rd_we  = ({ir[31], ir[29:26]} == 5'b0);
                    end
                    default: rd_we = 1'b0;
                endcase
            end
            OPC_OP: begin
                alu_b = rs2_val;
                rd_we = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD_SUB}: alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD_SUB}: alu_op = ALU_SUB;
                    {F7_BASE, F3_SLL}:     alu_op = ALU_SLL;
                    {F7_BASE, F3_SLT}:     alu_op = ALU_SLT;
                    {F7_BASE, F3_SLTU}:    alu_op = ALU_SLTU;
                    {F7_BASE, F3_XOR}:     alu_op = ALU_XOR;
                    {F7_BASE, F3_SRL_SRA}: alu_op = ALU_SRL;
                    {F7_ALT,  F3_SRL_SRA}: alu_op = ALU_SRA;
                    {F7_BASE, F3_OR}:      alu_op = ALU_OR;
                    {F7_BASE, F3_AND}:     alu_op = ALU_AND;
                    default:               rd_we  = 1'b0;
                endcase
            end
            OPC_OP_IMM_32: begin
                alu_word = 1'b1;
                case (funct3)
                    F3_ADD_SUB: begin
                        alu_op = ALU_ADD;
                        rd_we  = 1'b1;
                    end
                    F3_SLL: begin
                        alu_op = ALU_SLL;
                        rd_we  = (funct7 == F7_BASE);
                    end
                    F3_SRL_SRA: begin
                        alu_op = ir[30] ? ALU_SRA : ALU_SRL;
                        rd_we  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    default: rd_we = 1'b0;
                endcase
            end
            OPC_OP_32: begin
                alu_b    = rs2_val;
                alu_word = 1'b1;
                rd_we    = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD_SUB}: alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD_SUB}: alu_op = ALU_SUB;
                    {F7_BASE, F3_SLL}:     alu_op = ALU_SLL;
                    {F7_BASE, F3_SRL_SRA}: alu_op = ALU_SRL;
                    {F7_ALT,  F3_SRL_SRA}: alu_op = ALU_SRA;
                    default:               rd_we  = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // ALU: 64-bit result, or 32-bit word result sign-extended for the *W forms
    always_comb begin
        alu_raw  = '0;
        alu_wres = alu_a[31:0];
        case (alu_op)
            ALU_ADD:  alu_raw = alu_a + alu_b;
            ALU_SUB:  alu_raw = alu_a - alu_b;
            ALU_SLL:  alu_raw = alu_a << alu_b[5:0];
            ALU_SLT:  alu_raw = {63'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_raw = {63'b0, alu_a < alu_b};
            ALU_XOR:  alu_raw = alu_a ^ alu_b;
            ALU_SRL:  alu_raw = alu_a >> alu_b[5:0];
            ALU_SRA:  alu_raw = xlen_t'($signed(alu_a) >>> alu_b[5:0]);
            ALU_OR:   alu_raw = alu_a | alu_b;
            ALU_AND:  alu_raw = alu_a & alu_b;
            default:  alu_raw = '0;
        endcase
        case (alu_op)
            ALU_SLL: alu_wres = alu_a[31:0] << alu_b[4:0];
            ALU_SRL: alu_wres = alu_a[31:0] >> alu_b[4:0];
            ALU_SRA: alu_wres = 32'($signed(alu_a[31:0]) >>> alu_b[4:0]);
            default: alu_wres = alu_raw[31:0];
        endcase
        alu_res = alu_word ? sext32(alu_wres) : alu_raw;
    end

    // Branch condition evaluation
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val < rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Next-PC and write-back selection; PC low two bits always cleared
    always_comb begin
        pc_plus4  = pc_q + 64'd4;
        pc_target = pc_plus4;
        if (is_jal) begin
            pc_target = pc_q + imm_j;
        end else if (is_jalr) begin
            pc_target = (rs1_val + imm_i) & ~64'd1;
        end else if (is_branch && br_taken) begin
            pc_target = pc_q + imm_b;
        end
        pc_next = {pc_target[63:2], 2'b00};
        wb_data = link ? pc_plus4 : alu_res;
    end

    // PC register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Register file; x0 is never written
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (rd_we && (rd != 5'd0)) begin
            regs[rd] <= wb_data;
        end
    end

endmodule

// File: rtl/nona_rom.sv
// Instruction ROM: zero-latency combinational read, contents preloaded by the environment.
module nona_rom
    import nona_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 4096
) (
    input logic   clk_i,
    nona_if.slave bus
);

    logic [31:0] rom [ROM_DEPTH];

    // Combinational fetch, address already reduced modulo ROM_DEPTH
    always_comb begin
        bus.data = rom[bus.addr];
    end

    // Optional image load port; no reset so the array keeps whatever was preloaded
    always_ff @(posedge clk_i) begin
        if (bus.load_en) begin
            rom[bus.load_addr] <= bus.load_data;
        end
    end

endmodule

// File: rtl/nona_soc.sv
// SoC wrapper: one nona core with its internal instruction ROM; clock and reset only.
module nona_soc
    import nona_pkg::*;
#(
    parameter int unsigned ROM_DEPTH = 4096,
    parameter xlen_t       RESET_PC  = '0
) (
    input logic clk_i,
    input logic rst_ni
);

    nona_core #(
        .ROM_DEPTH (ROM_DEPTH),
        .RESET_PC  (RESET_PC)
    ) core (
        .clk_i  (clk_i),
        .rst_ni (rst_ni)
    );

endmodule

// File: tb/tb_nona_soc.sv
// Directed self-checking bench for nona_soc with small hand-assembled programs.
module tb_nona_soc;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    logic clk    = 1'b0;
    logic rst_ni = 1'b1;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always #5 clk = ~clk;

    nona_soc #(
        .ROM_DEPTH (DEPTH),
        .RESET_PC  (64'h0)
    ) soc (
        .clk_i  (clk),
        .rst_ni (rst_ni)
    );

    // Observation copy of the fetch bus
    nona_if #(.AW(AW)) fetch_view ();
    assign fetch_view.addr      = soc.core.rom_bus.addr;
    assign fetch_view.data      = soc.core.ir;
    assign fetch_view.load_en   = 1'b0;
    assign fetch_view.load_addr = '0;
    assign fetch_view.load_data = '0;

    // Instruction encoders
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] opc);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input logic [6:0] opc);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], opc};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] opc);
        return {imm[19:0], rd[4:0], opc};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_begin();
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            soc.core.async_rom.rom[i] = '0;
        end
    endtask

    task automatic load_end();
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        load_begin();
        soc.core.async_rom.rom[0] = 32'h00500093;
        soc.core.async_rom.rom[1] = enc_i(-3, 0, 0, 2, 7'h13);
        #100;
        n_cmp++;
        if (soc.core.pc_q !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_pc: got %h expected %h", soc.core.pc_q, 64'h0);
        end
        n_cmp++;
        if (soc.core.ir !== 32'h00500093) begin
            n_bad++;
            $display("FAIL reset_ir: got %h expected %h", soc.core.ir, 32'h00500093);
        end
        n_cmp++;
        if (soc.core.regs[1] !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_x1: got %h expected %h", soc.core.regs[1], 64'h0);
        end
        n_cmp++;
        if (fetch_view.addr !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_fetch_addr: got %h expected %h", fetch_view.addr, 6'd0);
        end
        load_end();
        step(1);
        n_cmp++;
        if (soc.core.pc_q !== 64'd4 || soc.core.regs[1] !== 64'd5) begin
            n_bad++;
            $display("FAIL reset_first_instr: pc %h x1 %h expected pc 4 x1 5", soc.core.pc_q, soc.core.regs[1]);
        end
        step(1);
        n_cmp++;
        if (soc.core.pc_q !== 64'd8 || soc.core.regs[2] !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_bad++;
            $display("FAIL reset_second_instr: pc %h x2 %h expected pc 8 x2 fffffffffffffffd", soc.core.pc_q, soc.core.regs[2]);
        end
    endtask

    task automatic test_arith();
        int          idx [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0};
        logic [63:0] exp [11] = '{64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'hFFFF_FFFF_FFFF_FFF8,
                                  64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h07FF_FFFF_FFFF_FFFF,
                                  64'hFFFF_FFFF_FFFF_FFF8, 64'h5000_0000_0000_0000, 64'd0};
        load_begin();
        soc.core.async_rom.rom[0]  = enc_i(5, 0, 0, 1, 7'h13);
        soc.core.async_rom.rom[1]  = enc_i(-3, 0, 0, 2, 7'h13);
        soc.core.async_rom.rom[2]  = enc_r(0, 2, 1, 0, 3, 7'h33);
        soc.core.async_rom.rom[3]  = enc_r(32, 1, 2, 0, 4, 7'h33);
        soc.core.async_rom.rom[4]  = enc_r(0, 1, 2, 2, 5, 7'h33);
        soc.core.async_rom.rom[5]  = enc_r(0, 1, 2, 3, 6, 7'h33);
        soc.core.async_rom.rom[6]  = enc_r(32, 1, 2, 5, 7, 7'h33);
        soc.core.async_rom.rom[7]  = enc_r(0, 1, 2, 5, 8, 7'h33);
        soc.core.async_rom.rom[8]  = enc_r(0, 2, 1, 4, 9, 7'h33);
        soc.core.async_rom.rom[9]  = enc_i(60, 1, 1, 10, 7'h13);
        soc.core.async_rom.rom[10] = enc_i(1, 1, 0, 1, 7'h13);
        load_end();
        step(11);
        foreach (idx[i]) begin
            n_cmp++;
            if (soc.core.regs[idx[i]] !== exp[i]) begin
                n_bad++;
                $display("FAIL arith_x%0d: got %h expected %h", idx[i], soc.core.regs[idx[i]], exp[i]);
            end
        end
        n_cmp++;
        if (soc.core.pc_q !== 64'd44) begin
            n_bad++;
            $display("FAIL arith_pc: got %h expected %h", soc.core.pc_q, 64'd44);
        end
    endtask

    task automatic test_branch_loop();
        logic [63:0] pcs [7] = '{64'd4, 64'd8, 64'd4, 64'd8, 64'd4, 64'd8, 64'd12};
        load_begin();
        soc.core.async_rom.rom[0] = enc_i(3, 0, 0, 1, 7'h13);
        soc.core.async_rom.rom[1] = enc_i(-1, 1, 0, 1, 7'h13);
        soc.core.async_rom.rom[2] = enc_b(-4, 0, 1, 1);
        load_end();
        n_cmp++;
        if (soc.core.pc_q !== 64'd0) begin
            n_bad++;
            $display("FAIL loop_pc0: got %h expected %h", soc.core.pc_q, 64'd0);
        end
        foreach (pcs[i]) begin
            step(1);
            n_cmp++;
            if (soc.core.pc_q !== pcs[i]) begin
                n_bad++;
                $display("FAIL loop_pc_step%0d: got %h expected %h", i + 1, soc.core.pc_q, pcs[i]);
            end
        end
        n_cmp++;
        if (soc.core.regs[1] !== 64'd0) begin
            n_bad++;
            $display("FAIL loop_x1: got %h expected %h", soc.core.regs[1], 64'd0);
        end
    endtask

    task automatic test_branch_types();
        logic [63:0] pcs [6] = '{64'd4, 64'd8, 64'd16, 64'd20, 64'd28, 64'd0};
        load_begin();
        soc.core.async_rom.rom[0] = enc_i(5, 0, 0, 1, 7'h13);
        soc.core.async_rom.rom[1] = enc_i(-3, 0, 0, 2, 7'h13);
        soc.core.async_rom.rom[2] = enc_b(8, 1, 2, 4);
        soc.core.async_rom.rom[4] = enc_b(8, 1, 2, 6);
        soc.core.async_rom.rom[5] = enc_b(8, 1, 2, 7);
        soc.core.async_rom.rom[7] = enc_b(-28, 2, 1, 5);
        load_end();
        foreach (pcs[i]) begin
            step(1);
            n_cmp++;
            if (soc.core.pc_q !== pcs[i]) begin
                n_bad++;
                $display("FAIL branch_pc_step%0d: got %h expected %h", i + 1, soc.core.pc_q, pcs[i]);
            end
        end
    endtask

    task automatic test_jumps();
        logic [63:0] pcs [4] = '{64'd16, 64'd4, 64'd8, 64'd4};
        load_begin();
        soc.core.async_rom.rom[0] = enc_j(16, 1);
        soc.core.async_rom.rom[1] = enc_u(1, 6, 7'h17);
        soc.core.async_rom.rom[2] = enc_i(3, 1, 0, 5, 7'h67);
        soc.core.async_rom.rom[4] = enc_i(0, 1, 0, 0, 7'h67);
        load_end();
        foreach (pcs[i]) begin
            step(1);
            n_cmp++;
            if (soc.core.pc_q !== pcs[i]) begin
                n_bad++;
                $display("FAIL jump_pc_step%0d: got %h expected %h", i + 1, soc.core.pc_q, pcs[i]);
            end
            if (i == 0) begin
                n_cmp++;
                if (soc.core.regs[1] !== 64'd4) begin
                    n_bad++;
                    $display("FAIL jal_link_x1: got %h expected %h", soc.core.regs[1], 64'd4);
                end
            end
        end
        n_cmp++;
        if (soc.core.regs[6] !== 64'h1004) begin
            n_bad++;
            $display("FAIL auipc_x6: got %h expected %h", soc.core.regs[6], 64'h1004);
        end
        n_cmp++;
        if (soc.core.regs[5] !== 64'd12) begin
            n_bad++;
            $display("FAIL jalr_link_x5: got %h expected %h", soc.core.regs[5], 64'd12);
        end
        n_cmp++;
        if (soc.core.regs[0] !== 64'd0) begin
            n_bad++;
            $display("FAIL jalr_x0: got %h expected %h", soc.core.regs[0], 64'd0);
        end
    endtask

    task automatic test_word_ops();
        int          idx [10] = '{5, 6, 0, 8, 9, 10, 11, 12, 13, 14};
        logic [63:0] exp [10] = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_7FFF_FFFF, 64'd0, 64'd1,
                                  64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0800_0000, 64'hFFFF_FFFF_F800_0000,
                                  64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_C000_0000};
        load_begin();
        soc.core.async_rom.rom[0] = enc_u(32'h80000, 5, 7'h37);
        soc.core.async_rom.rom[1] = enc_i(-1, 5, 0, 6, 7'h1B);
        soc.core.async_rom.rom[2] = enc_i(7, 0, 0, 0, 7'h13);
        soc.core.async_rom.rom[3] = enc_i(1, 0, 0, 8, 7'h13);
        soc.core.async_rom.rom[4] = enc_i(1, 6, 1, 9, 7'h1B);
        soc.core.async_rom.rom[5] = enc_i(4, 5, 5, 10, 7'h1B);
        soc.core.async_rom.rom[6] = enc_i(32'h404, 5, 5, 11, 7'h1B);
        soc.core.async_rom.rom[7] = enc_r(32, 5, 0, 0, 12, 7'h3B);
        soc.core.async_rom.rom[8] = enc_r(0, 8, 6, 0, 13, 7'h3B);
        soc.core.async_rom.rom[9] = enc_r(32, 8, 5, 5, 14, 7'h3B);
        load_end();
        step(10);
        foreach (idx[i]) begin
            n_cmp++;
            if (soc.core.regs[idx[i]] !== exp[i]) begin
                n_bad++;
                $display("FAIL word_x%0d: got %h expected %h", idx[i], soc.core.regs[idx[i]], exp[i]);
            end
        end
    endtask

    task automatic test_wrap_nop();
        logic [31:0] first;
        first = enc_i(256, 0, 0, 7, 7'h13);
        load_begin();
        soc.core.async_rom.rom[0] = first;
        soc.core.async_rom.rom[1] = 32'h0000_0000;
        soc.core.async_rom.rom[2] = 32'hFFFF_FFFF;
        soc.core.async_rom.rom[3] = enc_i(0, 7, 3, 4, 7'h03);
        soc.core.async_rom.rom[4] = enc_i(0, 7, 0, 0, 7'h67);
        load_end();
        step(4);
        n_cmp++;
        if (soc.core.pc_q !== 64'd16 || soc.core.regs[7] !== 64'd256) begin
            n_bad++;
            $display("FAIL nop_pc_x7: pc %h x7 %h expected pc 10 x7 100", soc.core.pc_q, soc.core.regs[7]);
        end
        n_cmp++;
        if (soc.core.regs[31] !== 64'd0 || soc.core.regs[4] !== 64'd0) begin
            n_bad++;
            $display("FAIL nop_no_write: x31 %h x4 %h expected both 0", soc.core.regs[31], soc.core.regs[4]);
        end
        step(1);
        n_cmp++;
        if (soc.core.pc_q !== 64'd256) begin
            n_bad++;
            $display("FAIL wrap_pc: got %h expected %h", soc.core.pc_q, 64'd256);
        end
        n_cmp++;
        if (soc.core.ir !== first || fetch_view.addr !== 6'd0) begin
            n_bad++;
            $display("FAIL wrap_fetch: ir %h addr %h expected ir %h addr 0", soc.core.ir, fetch_view.addr, first);
        end
        step(1);
        n_cmp++;
        if (soc.core.pc_q !== 64'd260) begin
            n_bad++;
            $display("FAIL wrap_next_pc: got %h expected %h", soc.core.pc_q, 64'd260);
        end
    endtask

    task automatic test_async_reset();
        load_begin();
        soc.core.async_rom.rom[0] = enc_i(5, 0, 0, 1, 7'h13);
        soc.core.async_rom.rom[1] = enc_i(9, 0, 0, 2, 7'h13);
        load_end();
        step(2);
        n_cmp++;
        if (soc.core.pc_q !== 64'd8 || soc.core.regs[2] !== 64'd9) begin
            n_bad++;
            $display("FAIL areset_pre: pc %h x2 %h expected pc 8 x2 9", soc.core.pc_q, soc.core.regs[2]);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (soc.core.pc_q !== 64'd0 || soc.core.regs[1] !== 64'd0 || soc.core.regs[2] !== 64'd0) begin
            n_bad++;
            $display("FAIL areset_immediate: pc %h x1 %h x2 %h expected all 0", soc.core.pc_q, soc.core.regs[1], soc.core.regs[2]);
        end
        step(2);
        n_cmp++;
        if (soc.core.pc_q !== 64'd0 || soc.core.regs[1] !== 64'd0) begin
            n_bad++;
            $display("FAIL areset_held: pc %h x1 %h expected both 0", soc.core.pc_q, soc.core.regs[1]);
        end
        load_end();
        step(1);
        n_cmp++;
        if (soc.core.pc_q !== 64'd4 || soc.core.regs[1] !== 64'd5) begin
            n_bad++;
            $display("FAIL areset_restart: pc %h x1 %h expected pc 4 x1 5", soc.core.pc_q, soc.core.regs[1]);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_branch_loop();
        test_branch_types();
        test_jumps();
        test_word_ops();
        test_wrap_nop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
